uart_rx: RTL and testbench

Serial receiver that recovers 8N1 frames from the asynchronous `rx` line using a 16x oversampling tick from the baud-rate generator. It sits directly upstream of the receive FIFO: `rx_done_tick` drives the FIFO `wr` input and `dout` drives its `write_data`, one pulse per correctly framed byte. Stop-bit violations are flagged on `frame_err` and never written.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_BIT    = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Reset value is a parameter so idle levels survive reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// Emits one strobe per good frame; bad stop bits raise frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(MID_BIT);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic [DBIT-1:0] dout_n;
  logic            done_n;
  logic            ferr_n;
  logic            stop_ok, stop_ok_n;
  logic            rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      stop_ok      <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
      stop_ok      <= stop_ok_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = s;
    n_n       = n;
    b_n       = b;
    dout_n    = dout;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    stop_ok_n = stop_ok;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          s_n     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_n = ST_DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            b_n = {rx_s, b[DBIT-1:1]};
            s_n = '0;
            if (n == N_LAST) state_n = ST_STOP;
            else n_n = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          s_n = s + 1'b1;
          if (s == S_MID) stop_ok_n = rx_s;
          if (s == S_STOP) begin
            state_n = ST_IDLE;
            if (stop_ok) begin
              dout_n = b;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: line edges land one clk after a tick.
// Pulse counts and captured bytes come from a negedge monitor.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  logic [1:0] tcnt = 2'd0;

  int passed = 0;
  int total  = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         dout_bad = 0;
  logic [7:0] last_dout = 8'h00;
  logic [7:0] prev_dout = 8'h00;
  time        done_time = 0;
  time        fall_time = 0;

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .s_tick      (s_tick),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) tcnt <= tcnt + 2'd1;
  assign s_tick = (tcnt == 2'd3);

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      last_dout = dout;
      done_time = $time;
    end
    if (frame_err) ferr_cnt++;
    if (rx_done_tick && frame_err) both_cnt++;
    if (reset && dout !== prev_dout && !rx_done_tick) dout_bad++;
    prev_dout = dout;
  end

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  task automatic idle_ticks(input int t);
    repeat (t) wait_tick();
  endtask

  task automatic drive_bit(input logic v, input int ticks);
    @(posedge clk);
    #1 rx = v;
    repeat (ticks) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int stop_ticks);
    drive_bit(1'b0, 0);
    fall_time = $time;
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    drive_bit(stop, stop_ticks);
    if (!stop) drive_bit(1'b1, 0);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout);
    else passed++;
    total++;
    if (rx_done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", rx_done_tick);
    else passed++;
    total++;
    if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err);
    else passed++;
    reset = 1'b1;
    idle_ticks(200);
    total++;
    if (done_cnt !== 0) $display("FAIL idle_done: got %0d want 0", done_cnt);
    else passed++;
    total++;
    if (ferr_cnt !== 0) $display("FAIL idle_ferr: got %0d want 0", ferr_cnt);
    else passed++;
  endtask

  task automatic test_good_frame();
    int bd;
    int bf;
    bd = done_cnt;
    bf = ferr_cnt;
    wait_tick();
    send_frame(8'h55, 1'b1, 16);
    idle_ticks(8);
    total++;
    if (done_cnt - bd !== 1) $display("FAIL good_done_cnt: got %0d want 1", done_cnt - bd);
    else passed++;
    total++;
    if (last_dout !== 8'h55) $display("FAIL good_dout: got %h want 55", last_dout);
    else passed++;
    total++;
    if (ferr_cnt - bf !== 0) $display("FAIL good_ferr: got %0d want 0", ferr_cnt - bf);
    else passed++;
    // 152 ticks after the detect edge, detect is 3 clk after the pin
    total++;
    if (done_time - fall_time !== 64'd6114)
      $display("FAIL good_latency: got %0t want 6114", done_time - fall_time);
    else passed++;
  endtask

  task automatic test_start_glitch();
    int bd;
    int bf;
    bd = done_cnt;
    bf = ferr_cnt;
    wait_tick();
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    total++;
    if (done_cnt - bd !== 0) $display("FAIL glitch_done: got %0d want 0", done_cnt - bd);
    else passed++;
    total++;
    if (ferr_cnt - bf !== 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - bf);
    else passed++;
    total++;
    if (dout !== 8'h55) $display("FAIL glitch_dout: got %h want 55", dout);
    else passed++;
    send_frame(8'h3C, 1'b1, 16);
    idle_ticks(8);
    total++;
    if (done_cnt - bd !== 1) $display("FAIL after_glitch_cnt: got %0d want 1", done_cnt - bd);
    else passed++;
    total++;
    if (dout !== 8'h3C) $display("FAIL after_glitch_dout: got %h want 3c", dout);
    else passed++;
  endtask

  task automatic test_frame_err();
    int bd;
    int bf;
    wait_tick();
    send_frame(8'h55, 1'b1, 16);
    idle_ticks(8);
    total++;
    if (dout !== 8'h55) $display("FAIL ferr_pre_dout: got %h want 55", dout);
    else passed++;
    bd = done_cnt;
    bf = ferr_cnt;
    send_frame(8'hA3, 1'b0, 12);
    idle_ticks(40);
    total++;
    if (ferr_cnt - bf !== 1) $display("FAIL ferr_cnt: got %0d want 1", ferr_cnt - bf);
    else passed++;
    total++;
    if (done_cnt - bd !== 0) $display("FAIL ferr_done: got %0d want 0", done_cnt - bd);
    else passed++;
    total++;
    if (dout !== 8'h55) $display("FAIL ferr_dout: got %h want 55", dout);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int bd;
    int bf;
    bd = done_cnt;
    bf = ferr_cnt;
    wait_tick();
    send_frame(8'h00, 1'b1, 16);
    total++;
    if (last_dout !== 8'h00 || done_cnt - bd !== 1)
      $display("FAIL b2b_first: got %h/%0d want 00/1", last_dout, done_cnt - bd);
    else passed++;
    send_frame(8'hFF, 1'b1, 16);
    idle_ticks(8);
    total++;
    if (done_cnt - bd !== 2) $display("FAIL b2b_cnt: got %0d want 2", done_cnt - bd);
    else passed++;
    total++;
    if (last_dout !== 8'hFF) $display("FAIL b2b_second: got %h want ff", last_dout);
    else passed++;
    total++;
    if (ferr_cnt - bf !== 0) $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - bf);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int bd;
    bd = done_cnt;
    wait_tick();
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 8);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if (dout !== 8'h00) $display("FAIL mid_reset_dout: got %h want 00", dout);
    else passed++;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle_ticks(40);
    total++;
    if (done_cnt - bd !== 0) $display("FAIL mid_reset_done: got %0d want 0", done_cnt - bd);
    else passed++;
    send_frame(8'h7E, 1'b1, 16);
    idle_ticks(8);
    total++;
    if (done_cnt - bd !== 1) $display("FAIL post_reset_cnt: got %0d want 1", done_cnt - bd);
    else passed++;
    total++;
    if (dout !== 8'h7E) $display("FAIL post_reset_dout: got %h want 7e", dout);
    else passed++;
  endtask

  task automatic test_invariants();
    total++;
    if (both_cnt !== 0) $display("FAIL both_high: got %0d want 0", both_cnt);
    else passed++;
    total++;
    if (dout_bad !== 0) $display("FAIL dout_no_strobe: got %0d want 0", dout_bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_start_glitch();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
